// File: rtl/mult_scoreboard_pkg.sv
// Shared constants for the multiply hazard scoreboard: default register
// address width and the stall cause encoding reported to decode.
package mult_scoreboard_pkg;

  localparam int REG_ADDR = 5;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_NONE     = 2'd0;
  localparam cause_t CAUSE_RAW_MULT = 2'd1;
  localparam cause_t CAUSE_WAW_PORT = 2'd2;
  localparam cause_t CAUSE_RAW_OPND = 2'd3;

endpackage

// File: rtl/mult_shadow_sreg.sv
// Shadow of the multiply pipeline: entry k mirrors stage Mk as {valid, dst}.
// The whole register freezes while hold is high.
module mult_shadow_sreg
  import mult_scoreboard_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hold,
  input  logic                       in_valid,
  input  logic [AW-1:0]              in_dst,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][AW-1:0]   ent_dst
);

  // Index 0 is M1; the top entry falls off the end when it retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      ent_dst   <= '0;
    end else if (!hold) begin
      ent_valid <= {ent_valid[DEPTH-2:0], in_valid};
      ent_dst   <= {ent_dst[DEPTH-2:0], in_dst};
    end
  end

endmodule

// File: rtl/mult_scoreboard.sv
// Decode-side hazard scoreboard for the multi-cycle multiplier: stall and cause,
// occupancy and stall-cycle counters. Define MULT_SCOREBOARD_FWD_EN to forward
// from the last multiply stage instead of stalling on it (adds fwd_sel).
module mult_scoreboard #(
  parameter int REG_ADDR    = mult_scoreboard_pkg::REG_ADDR,
  parameter int MULT_LAT    = 5,
  parameter int ALU_WB_DIST = 3,
  parameter int CNT_W       = 32,
  localparam int CNT_IW     = $clog2(MULT_LAT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [REG_ADDR-1:0] id_src1,
  input  logic [REG_ADDR-1:0] id_src2,
  input  logic [REG_ADDR-1:0] id_dst_reg,
  input  logic                id_regwrite,
  input  logic                id_is_mult,
  input  logic [REG_ADDR-1:0] id_ex_dst_reg,
  input  logic                id_ex_regwrite,
  input  logic [REG_ADDR-1:0] ex_mem_dst_reg,
  input  logic                ex_mem_regwrite,
  output logic                stall,
  output logic [1:0]          stall_cause,
  output logic                mult_busy,
  output logic [CNT_IW-1:0]   inflight_cnt,
  output logic [CNT_W-1:0]    stall_cycles
`ifdef MULT_SCOREBOARD_FWD_EN
  ,
  output logic [1:0]          fwd_sel
`endif
);

  import mult_scoreboard_pkg::*;

  // Stage whose result writes back together with an ALU op issued this cycle.
  localparam int KWB = MULT_LAT + 1 - ALU_WB_DIST;

  function automatic logic [MULT_LAT-1:0] low_mask(input int n);
    logic [MULT_LAT-1:0] m;
    m = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

`ifdef MULT_SCOREBOARD_FWD_EN
  localparam logic [MULT_LAT-1:0] RAW_MASK = low_mask(MULT_LAT - 1);
`else
  localparam logic [MULT_LAT-1:0] RAW_MASK = low_mask(MULT_LAT);
`endif
  localparam logic [MULT_LAT-1:0] WAW_MASK = low_mask(KWB);

  logic [MULT_LAT-1:0]               ent_valid;
  logic [MULT_LAT-1:0][REG_ADDR-1:0] ent_dst;
  logic [MULT_LAT-1:0]               hit1, hit2, hitd;
  logic                              raw_hit, waw_hit, opnd_hit;
  logic                              ex_hit, mem_hit;
  logic                              issue, shift_in;

  // Register 0 is never a real dependency, so it never matches.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    hitd = '0;
    for (int k = 0; k < MULT_LAT; k++) begin
      hit1[k] = ent_valid[k] && (id_src1 != '0) && (ent_dst[k] == id_src1);
      hit2[k] = ent_valid[k] && (id_src2 != '0) && (ent_dst[k] == id_src2);
      hitd[k] = ent_valid[k] && (id_dst_reg != '0) && (ent_dst[k] == id_dst_reg);
    end
  end

  assign ex_hit  = id_ex_regwrite &&
                   (((id_src1 != '0) && (id_src1 == id_ex_dst_reg)) ||
                    ((id_src2 != '0) && (id_src2 == id_ex_dst_reg)));
  assign mem_hit = ex_mem_regwrite &&
                   (((id_src1 != '0) && (id_src1 == ex_mem_dst_reg)) ||
                    ((id_src2 != '0) && (id_src2 == ex_mem_dst_reg)));

  assign raw_hit  = id_valid && (|((hit1 | hit2) & RAW_MASK));
  // Multiplies complete in order with equal latency, so only non-mult writers
  // can collide on the write port or overtake an older multiply.
  assign waw_hit  = id_valid && id_regwrite && !id_is_mult &&
                    (ent_valid[KWB-1] || (|(hitd & WAW_MASK)));
  assign opnd_hit = id_valid && id_is_mult && (ex_hit || mem_hit);

  always_comb begin
    stall_cause = CAUSE_NONE;
    if (raw_hit)       stall_cause = CAUSE_RAW_MULT;
    else if (opnd_hit) stall_cause = CAUSE_RAW_OPND;
    else if (waw_hit)  stall_cause = CAUSE_WAW_PORT;
  end

  assign stall = (stall_cause != CAUSE_NONE);

`ifdef MULT_SCOREBOARD_FWD_EN
  // Forward only when no younger in-flight copy of the register exists.
  assign fwd_sel[0] = id_valid && hit1[MULT_LAT-1] && !(|(hit1 & RAW_MASK));
  assign fwd_sel[1] = id_valid && hit2[MULT_LAT-1] && !(|(hit2 & RAW_MASK));
`endif

  assign issue    = id_valid && id_is_mult && id_regwrite && !stall && !flush && !hold;
  assign shift_in = issue && (id_dst_reg != '0);

  mult_shadow_sreg #(
    .DEPTH (MULT_LAT),
    .AW    (REG_ADDR)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .in_valid  (shift_in),
    .in_dst    (id_dst_reg),
    .ent_valid (ent_valid),
    .ent_dst   (ent_dst)
  );

  // Occupancy is a population count, so issue-with-retire nets out naturally.
  always_comb begin
    inflight_cnt = '0;
    for (int k = 0; k < MULT_LAT; k++) begin
      inflight_cnt = inflight_cnt + CNT_IW'(ent_valid[k]);
    end
  end

  assign mult_busy = |ent_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && !hold && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_scoreboard.sv
// Scoreboard bench for mult_scoreboard: driver predicts each cycle's outputs from
// a list of in-flight multiplies with ages; a negedge monitor pops and compares.
module tb_mult_scoreboard;

  localparam int ML    = 5;
  localparam int KWB   = 3;
  localparam int CW    = 4;
  localparam int SCMAX = 15;

  typedef struct packed {
    logic       rst, hold, flush, v;
    logic [4:0] s1, s2, d;
    logic       rw, mul;
    logic [4:0] exd;
    logic       exrw;
    logic [4:0] memd;
    logic       memrw;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  cause;
    logic [2:0]  cnt;
    logic        busy;
    logic [CW-1:0] sc;
    logic [1:0]  fwd;
  } exp_t;

  typedef struct packed {
    int dst;
    int age;
  } fl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, hold, flush, id_valid, id_regwrite, id_is_mult;
  logic [4:0]    id_src1, id_src2, id_dst_reg, id_ex_dst_reg, ex_mem_dst_reg;
  logic          id_ex_regwrite, ex_mem_regwrite;
  logic          stall, mult_busy;
  logic [1:0]    stall_cause;
  logic [2:0]    inflight_cnt;
  logic [CW-1:0] stall_cycles;
`ifdef MULT_SCOREBOARD_FWD_EN
  logic [1:0]    fwd_sel;
`endif

  mult_scoreboard #(
    .REG_ADDR    (5),
    .MULT_LAT    (ML),
    .ALU_WB_DIST (3),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .hold            (hold),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_dst_reg      (id_dst_reg),
    .id_regwrite     (id_regwrite),
    .id_is_mult      (id_is_mult),
    .id_ex_dst_reg   (id_ex_dst_reg),
    .id_ex_regwrite  (id_ex_regwrite),
    .ex_mem_dst_reg  (ex_mem_dst_reg),
    .ex_mem_regwrite (ex_mem_regwrite),
    .stall           (stall),
    .stall_cause     (stall_cause),
    .mult_busy       (mult_busy),
    .inflight_cnt    (inflight_cnt),
    .stall_cycles    (stall_cycles)
`ifdef MULT_SCOREBOARD_FWD_EN
    ,
    .fwd_sel         (fwd_sel)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  fl_t  fl[$];
  int   sc_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: each in-flight multiply is {dst, age}; age k means stage Mk.
  function automatic exp_t predict(input stim_t s);
    exp_t       e;
    logic [1:0] lastm, youngm;
    logic       raw, waw, opnd, exh, memh;
    e = '0;
    lastm = '0;
    youngm = '0;
    waw = 1'b0;
    foreach (fl[i]) begin
      if (s.s1 != 0 && fl[i].dst == int'(s.s1)) begin
        if (fl[i].age == ML) lastm[0] = 1'b1; else youngm[0] = 1'b1;
      end
      if (s.s2 != 0 && fl[i].dst == int'(s.s2)) begin
        if (fl[i].age == ML) lastm[1] = 1'b1; else youngm[1] = 1'b1;
      end
      if (fl[i].age == KWB) waw = 1'b1;
      if (fl[i].age <= KWB && s.d != 0 && fl[i].dst == int'(s.d)) waw = 1'b1;
    end
`ifdef MULT_SCOREBOARD_FWD_EN
    raw = s.v && (youngm != 2'b00);
    e.fwd = s.v ? (lastm & ~youngm) : 2'b00;
`else
    raw = s.v && ((youngm | lastm) != 2'b00);
`endif
    waw  = waw && s.v && s.rw && !s.mul;
    exh  = s.exrw && ((s.s1 != 0 && s.s1 == s.exd) || (s.s2 != 0 && s.s2 == s.exd));
    memh = s.memrw && ((s.s1 != 0 && s.s1 == s.memd) || (s.s2 != 0 && s.s2 == s.memd));
    opnd = s.v && s.mul && (exh || memh);
    if (raw)       e.cause = 2'd1;
    else if (opnd) e.cause = 2'd3;
    else if (waw)  e.cause = 2'd2;
    else           e.cause = 2'd0;
    e.stall = (e.cause != 2'd0);
    e.cnt   = 3'(fl.size());
    e.busy  = (fl.size() != 0);
    e.sc    = CW'(sc_m);
    return e;
  endfunction

  task automatic advance(input stim_t s, input exp_t e);
    fl_t nq[$];
    if (s.rst) begin
      fl.delete();
      sc_m = 0;
    end else if (!s.hold) begin
      if (e.stall && sc_m < SCMAX) sc_m++;
      foreach (fl[i]) begin
        if (fl[i].age < ML) nq.push_back('{dst: fl[i].dst, age: fl[i].age + 1});
      end
      if (s.v && s.mul && s.rw && !e.stall && !s.flush && s.d != 0)
        nq.push_back('{dst: int'(s.d), age: 1});
      fl = nq;
    end
  endtask

  // Called just after a posedge: drive, predict, then let one edge pass.
  task automatic cyc(input stim_t s);
    exp_t e;
    reset = s.rst; hold = s.hold; flush = s.flush; id_valid = s.v;
    id_src1 = s.s1; id_src2 = s.s2; id_dst_reg = s.d;
    id_regwrite = s.rw; id_is_mult = s.mul;
    id_ex_dst_reg = s.exd; id_ex_regwrite = s.exrw;
    ex_mem_dst_reg = s.memd; ex_mem_regwrite = s.memrw;
    e = predict(s);
    exp_q.push_back(e);
    @(posedge clk);
    advance(s, e);
    #1;
  endtask

  function automatic stim_t op(input logic mul, input logic [4:0] d, input logic [4:0] a,
                               input logic [4:0] b);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rw = 1'b1; s.mul = mul; s.d = d; s.s1 = a; s.s2 = b;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.rst   = ($urandom_range(0, 99) < 1);
    s.hold  = ($urandom_range(0, 99) < 10);
    s.flush = ($urandom_range(0, 99) < 8);
    s.v     = ($urandom_range(0, 99) < 90);
    s.mul   = ($urandom_range(0, 99) < 40);
    s.rw    = ($urandom_range(0, 99) < 85);
    s.s1    = 5'($urandom_range(0, 7));
    s.s2    = 5'($urandom_range(0, 7));
    s.d     = 5'($urandom_range(0, 7));
    s.exd   = 5'($urandom_range(0, 7));
    s.exrw  = $urandom_range(0, 1);
    s.memd  = 5'($urandom_range(0, 7));
    s.memrw = $urandom_range(0, 1);
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("stall_cause", 32'(stall_cause), 32'(e.cause));
        chk("inflight_cnt", 32'(inflight_cnt), 32'(e.cnt));
        chk("mult_busy", 32'(mult_busy), 32'(e.busy));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
`ifdef MULT_SCOREBOARD_FWD_EN
        chk("fwd_sel", 32'(fwd_sel), 32'(e.fwd));
`endif
      end
    end
  end

  initial begin : driver
    stim_t s;
    s = '0;
    reset = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_src1 = '0; id_src2 = '0; id_dst_reg = '0; id_regwrite = 1'b0; id_is_mult = 1'b0;
    id_ex_dst_reg = '0; id_ex_regwrite = 1'b0; ex_mem_dst_reg = '0; ex_mem_regwrite = 1'b0;
    @(posedge clk);
    #1;
    s.rst = 1'b1;
    cyc(s);

    // Lone multiply travels through all stages and retires.
    cyc(op(1, 4, 1, 2));
    repeat (6) cyc('0);

    // RAW on a multiply result at every stage.
    cyc(op(1, 4, 1, 2));
    repeat (6) cyc(op(0, 5, 4, 1));

    // Write-port conflict at the writeback-aligned stage, gone one stage later.
    cyc(op(1, 7, 1, 2));
    repeat (2) cyc('0);
    repeat (2) cyc(op(0, 9, 1, 2));
    repeat (3) cyc('0);

    // Multiply operand produced by a load in EX, then MEM, then gone.
    s = op(1, 3, 2, 6);
    s.exd = 5'd2; s.exrw = 1'b1;
    cyc(s);
    s.exd = 5'd0; s.exrw = 1'b0; s.memd = 5'd2; s.memrw = 1'b1;
    cyc(s);
    s.memd = 5'd0; s.memrw = 1'b0;
    cyc(s);

    // Hold freezes shadow and stall counter; flush blocks a multiply issue.
    cyc(op(1, 8, 1, 2));
    s = op(0, 1, 8, 2);
    s.hold = 1'b1;
    repeat (3) cyc(s);
    s = op(1, 10, 1, 2);
    s.flush = 1'b1;
    cyc(s);
    repeat (6) cyc('0);

    // Enough dependent stalls to saturate the narrow stall counter.
    repeat (4) begin
      cyc(op(1, 4, 1, 2));
      repeat (6) cyc(op(0, 5, 4, 1));
    end

    // Four multiplies in flight, then reset clears everything.
    cyc(op(1, 11, 1, 2));
    cyc(op(1, 12, 1, 2));
    cyc(op(1, 13, 1, 2));
    cyc(op(1, 14, 1, 2));
    s = '0;
    s.rst = 1'b1;
    cyc(s);
    repeat (2) cyc('0);

    repeat (3000) cyc(rand_stim());

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
